// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage pipelined ALU with valid/ready handshakes, an
//                internal accumulator, signed/unsigned status flags,
//                invalid-opcode reporting and a saturating overflow counter.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1          clock, rising edge
//    rst_n      in   1          asynchronous active-low reset
//    in_valid   in   1          operand/opcode valid
//    in_ready   out  1          block can accept this cycle
//    op         in   4          opcode
//    a, b       in   WIDTH      operands
//    out_valid  out  1          result valid
//    out_ready  in   1          consumer accepts result
//    result     out  WIDTH      result
//    carry      out  1          carry / borrow / last bit shifted out
//    zero       out  1          result==0 (CMP: a==b)
//    neg        out  1          result MSB (CMP: signed a<b)
//    ovf        out  1          signed overflow
//    err        out  1          invalid opcode
//    acc        out  WIDTH      accumulator value
//    ovf_cnt    out  OVF_CNT_W  saturating count of delivered ovf results
// ============================================================================
module alu_pipe #(
   parameter int WIDTH     = 5,
   parameter int OVF_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           op,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     result,
   output logic                 carry,
   output logic                 zero,
   output logic                 neg,
   output logic                 ovf,
   output logic                 err,
   output logic [WIDTH-1:0]     acc,
   output logic [OVF_CNT_W-1:0] ovf_cnt
);

   localparam int       c_SHW  = $clog2(WIDTH);
   localparam int       c_MSB  = WIDTH - 1;

   localparam logic [3:0] c_OP_ADD    = 4'h0;
   localparam logic [3:0] c_OP_SUB    = 4'h1;
   localparam logic [3:0] c_OP_AND    = 4'h2;
   localparam logic [3:0] c_OP_OR     = 4'h3;
   localparam logic [3:0] c_OP_XOR    = 4'h4;
   localparam logic [3:0] c_OP_NOT    = 4'h5;
   localparam logic [3:0] c_OP_SHL    = 4'h6;
   localparam logic [3:0] c_OP_SHR    = 4'h7;
   localparam logic [3:0] c_OP_CMP    = 4'h8;
   localparam logic [3:0] c_OP_INC    = 4'h9;
   localparam logic [3:0] c_OP_DEC    = 4'hA;
   localparam logic [3:0] c_OP_ACC    = 4'hB;
   localparam logic [3:0] c_OP_CLRACC = 4'hC;

   // Stage 1 registers
   logic                 r_s1_valid;
   logic [3:0]           r_s1_op;
   logic [WIDTH-1:0]     r_s1_a;
   logic [WIDTH-1:0]     r_s1_b;

   // Stage 2 (output) registers
   logic                 r_s2_valid;
   logic [WIDTH-1:0]     r_result;
   logic                 r_carry;
   logic                 r_zero;
   logic                 r_neg;
   logic                 r_ovf;
   logic                 r_err;

   logic [WIDTH-1:0]     r_acc;
   logic [OVF_CNT_W-1:0] r_ovf_cnt;

   // Handshake
   logic w_s2_ready;
   logic w_s1_adv;

   assign w_s2_ready = !r_s2_valid || out_ready;
   assign in_ready   = !r_s1_valid || w_s2_ready;
   assign w_s1_adv   = r_s1_valid && w_s2_ready;

   // Arithmetic kernels, all one bit wider to expose carry/borrow
   logic [WIDTH:0]   w_add_ext;
   logic [WIDTH:0]   w_sub_ext;
   logic [WIDTH:0]   w_inc_ext;
   logic [WIDTH:0]   w_dec_ext;
   logic [WIDTH:0]   w_acc_ext;
   logic [WIDTH:0]   w_shl_ext;
   logic [WIDTH:0]   w_shr_ext;
   logic [c_SHW-1:0] w_shamt;
   logic             w_sub_ovf;

   assign w_add_ext = {1'b0, r_s1_a} + {1'b0, r_s1_b};
   assign w_sub_ext = {1'b0, r_s1_a} - {1'b0, r_s1_b};
   assign w_inc_ext = {1'b0, r_s1_a} + (WIDTH+1)'(1);
   assign w_dec_ext = {1'b0, r_s1_a} - (WIDTH+1)'(1);
   assign w_acc_ext = {1'b0, r_acc}  + {1'b0, r_s1_a};
   assign w_shamt   = r_s1_b[c_SHW-1:0];
   // The extra bit catches the last bit shifted out; amounts >= WIDTH
   // push every operand bit past the result field, giving 0.
   assign w_shl_ext = {1'b0, r_s1_a} << w_shamt;
   assign w_shr_ext = {r_s1_a, 1'b0} >> w_shamt;
   assign w_sub_ovf = (r_s1_a[c_MSB] != r_s1_b[c_MSB]) &&
                      (w_sub_ext[c_MSB] != r_s1_a[c_MSB]);

   // Result / flag computation for the transaction sitting in S1
   logic [WIDTH-1:0] w_res;
   logic             w_carry;
   logic             w_zero;
   logic             w_neg;
   logic             w_ovf;
   logic             w_err;
   logic             w_flags_from_res;
   logic             w_acc_wr;
   logic [WIDTH-1:0] w_acc_nxt;

   always_comb begin
      w_res            = '0;
      w_carry          = 1'b0;
      w_zero           = 1'b0;
      w_neg            = 1'b0;
      w_ovf            = 1'b0;
      w_err            = 1'b0;
      w_flags_from_res = 1'b1;
      w_acc_wr         = 1'b0;
      w_acc_nxt        = r_acc;
      case (r_s1_op)
         c_OP_ADD: begin
            w_res   = w_add_ext[WIDTH-1:0];
            w_carry = w_add_ext[WIDTH];
            w_ovf   = (r_s1_a[c_MSB] == r_s1_b[c_MSB]) &&
                      (w_add_ext[c_MSB] != r_s1_a[c_MSB]);
         end
         c_OP_SUB: begin
            w_res   = w_sub_ext[WIDTH-1:0];
            w_carry = w_sub_ext[WIDTH];
            w_ovf   = w_sub_ovf;
         end
         c_OP_AND: w_res = r_s1_a & r_s1_b;
         c_OP_OR:  w_res = r_s1_a | r_s1_b;
         c_OP_XOR: w_res = r_s1_a ^ r_s1_b;
         c_OP_NOT: w_res = ~r_s1_a;
         c_OP_SHL: begin
            w_res   = w_shl_ext[WIDTH-1:0];
            w_carry = w_shl_ext[WIDTH];
         end
         c_OP_SHR: begin
            w_res   = w_shr_ext[WIDTH:1];
            w_carry = w_shr_ext[0];
         end
         c_OP_CMP: begin
            // Result is forced to 0; flags describe a-b instead.
            w_flags_from_res = 1'b0;
            w_carry          = w_sub_ext[WIDTH];
            w_ovf            = w_sub_ovf;
            w_zero           = (r_s1_a == r_s1_b);
            w_neg            = w_sub_ext[c_MSB] ^ w_sub_ovf;
         end
         c_OP_INC: begin
            w_res   = w_inc_ext[WIDTH-1:0];
            w_carry = w_inc_ext[WIDTH];
            w_ovf   = !r_s1_a[c_MSB] && w_inc_ext[c_MSB];
         end
         c_OP_DEC: begin
            w_res   = w_dec_ext[WIDTH-1:0];
            w_carry = w_dec_ext[WIDTH];
            w_ovf   = r_s1_a[c_MSB] && !w_dec_ext[c_MSB];
         end
         c_OP_ACC: begin
            w_res     = w_acc_ext[WIDTH-1:0];
            w_carry   = w_acc_ext[WIDTH];
            w_ovf     = (r_acc[c_MSB] == r_s1_a[c_MSB]) &&
                        (w_acc_ext[c_MSB] != r_acc[c_MSB]);
            w_acc_wr  = 1'b1;
            w_acc_nxt = w_acc_ext[WIDTH-1:0];
         end
         c_OP_CLRACC: begin
            w_acc_wr  = 1'b1;
            w_acc_nxt = '0;
         end
         default: begin
            // Invalid opcode: every flag other than err stays low.
            w_flags_from_res = 1'b0;
            w_err            = 1'b1;
         end
      endcase
      if (w_flags_from_res) begin
         w_zero = (w_res == '0);
         w_neg  = w_res[c_MSB];
      end
   end

   // Stage 1: capture operands whenever the block is able to accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= '0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
      end else if (in_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_op <= op;
            r_s1_a  <= a;
            r_s1_b  <= b;
         end
      end
   end

   // Stage 2: register result and flags; holds while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_result   <= '0;
         r_carry    <= 1'b0;
         r_zero     <= 1'b0;
         r_neg      <= 1'b0;
         r_ovf      <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_s2_ready) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_result <= w_res;
            r_carry  <= w_carry;
            r_zero   <= w_zero;
            r_neg    <= w_neg;
            r_ovf    <= w_ovf;
            r_err    <= w_err;
         end
      end
   end

   // Accumulator commits as the ACC/CLRACC transaction leaves S1, so a
   // directly following ACC in S1 already sees the updated value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (w_s1_adv && w_acc_wr) begin
         r_acc <= w_acc_nxt;
      end
   end

   // Overflow events counted on delivery, saturating at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf_cnt <= '0;
      end else if (r_s2_valid && out_ready && r_ovf && (r_ovf_cnt != '1)) begin
         r_ovf_cnt <= r_ovf_cnt + OVF_CNT_W'(1);
      end
   end

   assign out_valid = r_s2_valid;
   assign result    = r_result;
   assign carry     = r_carry;
   assign zero      = r_zero;
   assign neg       = r_neg;
   assign ovf       = r_ovf;
   assign err       = r_err;
   assign acc       = r_acc;
   assign ovf_cnt   = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Directed, table-driven self-checking bench for alu_pipe
//                (WIDTH=5, OVF_CNT_W=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] op;
   logic [4:0] a;
   logic [4:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] result;
   logic       carry;
   logic       zero;
   logic       neg;
   logic       ovf;
   logic       err;
   logic [4:0] acc;
   logic [1:0] ovf_cnt;

   alu_pipe #(.WIDTH(5), .OVF_CNT_W(2)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry     (carry),
      .zero      (zero),
      .neg       (neg),
      .ovf       (ovf),
      .err       (err),
      .acc       (acc),
      .ovf_cnt   (ovf_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] op;
      logic [4:0] a;
      logic [4:0] b;
      logic [4:0] res;
      logic       c;
      logic       z;
      logic       n;
      logic       v;
      logic       e;
   } vec_t;

   localparam int NV = 26;
   vec_t tbl [NV];

   int checks  = 0;
   int errors  = 0;
   int exp_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=handshake", nm);
   endtask

   // Drive one cycle's inputs at the falling edge, settle, return.
   task automatic drive(input logic v, input logic [3:0] o, input logic [4:0] x,
                        input logic [4:0] y, input logic rdy);
      @(negedge clk);
      in_valid  = v;
      op        = o;
      a         = x;
      b         = y;
      out_ready = rdy;
      #1;
   endtask

   // One isolated transaction: send, wait for result, check all outputs,
   // then check the overflow counter after the result is consumed.
   task automatic run_vec(input vec_t v, input string tag);
      int n;
      drive(1'b1, v.op, v.a, v.b, 1'b1);
      n = 0;
      while (!in_ready && n < 20) begin
         drive(1'b1, v.op, v.a, v.b, 1'b1);
         n++;
      end
      if (!in_ready) begin
         fail_now({tag, "_accept"});
         drive(1'b0, 4'h0, 5'd0, 5'd0, 1'b1);
         return;
      end
      drive(1'b0, 4'h0, 5'd0, 5'd0, 1'b1);
      n = 0;
      while (!out_valid && n < 10) begin
         drive(1'b0, 4'h0, 5'd0, 5'd0, 1'b1);
         n++;
      end
      if (!out_valid) begin
         fail_now({tag, "_out"});
         return;
      end
      chk(tag, 32'({result, carry, zero, neg, ovf, err}),
               32'({v.res, v.c, v.z, v.n, v.v, v.e}));
      if (v.v && exp_cnt != 3) exp_cnt++;
      drive(1'b0, 4'h0, 5'd0, 5'd0, 1'b1);
      chk({tag, "_ovfcnt"}, 32'(ovf_cnt), 32'(exp_cnt));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] res_q [$];
      int         cyc_q [$];
      logic [4:0] exp_q [$];
      logic [4:0] accv [3];
      logic [4:0] held;
      int         n_acc;
      int         n_got;
      int         stall_bad;
      int         ov_seen;
      vec_t       v;

      //            op     a      b      res    c  z  n  v  e
      tbl[0]  = '{4'h0, 5'd20, 5'd15, 5'd3,  1, 0, 0, 0, 0};
      tbl[1]  = '{4'h1, 5'd5,  5'd7,  5'd30, 1, 0, 1, 0, 0};
      tbl[2]  = '{4'h0, 5'd15, 5'd1,  5'd16, 0, 0, 1, 1, 0};
      tbl[3]  = '{4'h2, 5'd12, 5'd10, 5'd8,  0, 0, 0, 0, 0};
      tbl[4]  = '{4'h3, 5'd16, 5'd1,  5'd17, 0, 0, 1, 0, 0};
      tbl[5]  = '{4'h4, 5'd21, 5'd21, 5'd0,  0, 1, 0, 0, 0};
      tbl[6]  = '{4'h5, 5'd5,  5'd0,  5'd26, 0, 0, 1, 0, 0};
      tbl[7]  = '{4'h6, 5'd19, 5'd1,  5'd6,  1, 0, 0, 0, 0};
      tbl[8]  = '{4'h6, 5'd19, 5'd5,  5'd0,  1, 1, 0, 0, 0};
      tbl[9]  = '{4'h7, 5'd19, 5'd2,  5'd4,  1, 0, 0, 0, 0};
      tbl[10] = '{4'h7, 5'd8,  5'd6,  5'd0,  0, 1, 0, 0, 0};
      tbl[11] = '{4'h8, 5'd3,  5'd9,  5'd0,  1, 0, 1, 0, 0};
      tbl[12] = '{4'h8, 5'd9,  5'd9,  5'd0,  0, 1, 0, 0, 0};
      tbl[13] = '{4'h9, 5'd31, 5'd0,  5'd0,  1, 1, 0, 0, 0};
      tbl[14] = '{4'h9, 5'd15, 5'd0,  5'd16, 0, 0, 1, 1, 0};
      tbl[15] = '{4'hA, 5'd0,  5'd0,  5'd31, 1, 0, 1, 0, 0};
      tbl[16] = '{4'hA, 5'd16, 5'd0,  5'd15, 0, 0, 0, 1, 0};
      tbl[17] = '{4'hE, 5'd9,  5'd9,  5'd0,  0, 0, 0, 0, 1};
      tbl[18] = '{4'h0, 5'd1,  5'd1,  5'd2,  0, 0, 0, 0, 0};
      tbl[19] = '{4'h0, 5'd8,  5'd8,  5'd16, 0, 0, 1, 1, 0};
      tbl[20] = '{4'h0, 5'd16, 5'd16, 5'd0,  1, 1, 0, 1, 0};
      tbl[21] = '{4'hF, 5'd31, 5'd31, 5'd0,  0, 0, 0, 0, 1};
      tbl[22] = '{4'h8, 5'd20, 5'd3,  5'd0,  0, 0, 1, 0, 0};
      tbl[23] = '{4'h1, 5'd16, 5'd1,  5'd15, 0, 0, 0, 1, 0};
      tbl[24] = '{4'hD, 5'd1,  5'd2,  5'd0,  0, 0, 0, 0, 1};
      tbl[25] = '{4'h8, 5'd3,  5'd20, 5'd0,  1, 0, 0, 0, 0};

      // ---------------- reset state ----------------
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      op        = 4'h0;
      a         = 5'd0;
      b         = 5'd0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_outputs", 32'({out_valid, result, carry, zero, neg, ovf, err}), 32'd0);
      chk("rst_acc", 32'(acc), 32'd0);
      chk("rst_ovfcnt", 32'(ovf_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // ---------------- opcode table ----------------
      for (int i = 0; i < NV; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // ---------------- back-to-back ACC chaining ----------------
      accv[0] = 5'd3;
      accv[1] = 5'd4;
      accv[2] = 5'd5;
      for (int c = 0; c < 8; c++) begin
         if (c < 3) drive(1'b1, 4'hB, accv[c], 5'd0, 1'b1);
         else       drive(1'b0, 4'h0, 5'd0, 5'd0, 1'b1);
         if (out_valid) begin
            res_q.push_back(result);
            cyc_q.push_back(c);
         end
      end
      chk("acc_count", 32'(res_q.size()), 32'd3);
      if (res_q.size() == 3) begin
         chk("acc_res0", 32'(res_q[0]), 32'd3);
         chk("acc_res1", 32'(res_q[1]), 32'd7);
         chk("acc_res2", 32'(res_q[2]), 32'd12);
         chk("acc_gap01", 32'(cyc_q[1] - cyc_q[0]), 32'd1);
         chk("acc_gap12", 32'(cyc_q[2] - cyc_q[1]), 32'd1);
      end
      chk("acc_value", 32'(acc), 32'd12);

      // ---------------- reset with transactions in flight ----------------
      drive(1'b1, 4'h0, 5'd1, 5'd1, 1'b0);
      drive(1'b1, 4'h0, 5'd2, 5'd2, 1'b0);
      drive(1'b0, 4'h0, 5'd0, 5'd0, 1'b0);
      chk("inflight_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_acc", 32'(acc), 32'd0);
      chk("arst_ovfcnt", 32'(ovf_cnt), 32'd0);
      chk("arst_result", 32'(result), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      exp_cnt = 0;
      ov_seen = 0;
      for (int c = 0; c < 6; c++) begin
         drive(1'b0, 4'h0, 5'd0, 5'd0, 1'b1);
         if (out_valid) ov_seen++;
      end
      chk("arst_no_stale", 32'(ov_seen), 32'd0);

      // ---------------- ACC from cleared accumulator, then CLRACC -------------
      v = '{4'hB, 5'd12, 5'd0, 5'd12, 0, 0, 0, 0, 0};
      run_vec(v, "acc12");
      chk("acc12_value", 32'(acc), 32'd12);
      v = '{4'hC, 5'd7, 5'd7, 5'd0, 0, 1, 0, 0, 0};
      run_vec(v, "clracc");
      chk("clracc_value", 32'(acc), 32'd0);

      // ---------------- output stall with continuous input ----------------
      n_acc     = 0;
      stall_bad = 0;
      held      = 5'd0;
      for (int c = 0; c < 5; c++) begin
         drive(1'b1, 4'h0, 5'(n_acc + 1), 5'd1, 1'b0);
         if (c == 2) held = result;
         if (c > 2 && result != held) stall_bad++;
         if (in_valid && in_ready) begin
            exp_q.push_back(5'(n_acc + 2));
            n_acc++;
         end
      end
      chk("stall_accepted", 32'(n_acc), 32'd2);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_first_res", 32'(held), 32'd2);
      chk("stall_hold", 32'(stall_bad), 32'd0);
      n_got = 0;
      for (int c = 0; c < 30 && n_got < 5; c++) begin
         drive(n_acc < 5, 4'h0, 5'(n_acc + 1), 5'd1, 1'b1);
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) chk($sformatf("drain%0d", n_got), 32'(result),
                                      32'(exp_q.pop_front()));
            else fail_now("drain_extra");
            n_got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(5'(n_acc + 2));
            n_acc++;
         end
      end
      drive(1'b0, 4'h0, 5'd0, 5'd0, 1'b1);
      chk("drain_count", 32'(n_got), 32'd5);
      chk("drain_leftover", 32'(exp_q.size()), 32'd0);
      chk("drain_idle", 32'(out_valid), 32'd0);

      // ---------------- overflow counter saturation ----------------
      for (int i = 0; i < 5; i++) run_vec(tbl[19], $sformatf("sat%0d", i));
      chk("sat_final", 32'(ovf_cnt), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
